// File: rtl/l2_arb_types.sv
// Shared types and defaults for the L2 port arbiter.
package l2_arb_types;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t SERVE_I = 2'd1;
  localparam arb_state_t SERVE_D = 2'd2;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way chooser between the L1I and L1D requests: round-robin or fixed D priority.
module arb_rr_pick #(
  parameter int unsigned D_PRIORITY = 0
) (
  input  logic i_req,
  input  logic d_req,
  input  logic last_served_d,  // 1 = D side was granted most recently
  output logic grant_i,
  output logic grant_d
);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      if ((D_PRIORITY != 0) || !last_served_d) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b1;
      end
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Serializes L1I and L1D line transactions onto the single L2 port, one at a time,
// and exports grant/contention strobes for the performance counters.
module l2_arbiter
  import l2_arb_types::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned LINE_W     = LINE_W_DEF,
  parameter int unsigned D_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              busy,
  output logic              i_grant_pulse,
  output logic              d_grant_pulse,
  output logic              contention_pulse
);

  arb_state_t        state_q, state_d;
  arb_op_t           op_q, op_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              i_grant_q, i_grant_d;
  logic              d_grant_q, d_grant_d;
  logic              cont_q, cont_d;

  logic i_req, d_req, grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  arb_rr_pick #(
    .D_PRIORITY(D_PRIORITY)
  ) u_pick (
    .i_req        (i_req),
    .d_req        (d_req),
    .last_served_d(last_d_q),
    .grant_i      (grant_i),
    .grant_d      (grant_d)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_grant_d = 1'b0;
    d_grant_d = 1'b0;
    cont_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cont_d = i_req & d_req;
        if (grant_i) begin
          state_d   = SERVE_I;
          op_d      = OP_READ;
          addr_d    = i_address;
          last_d_d  = 1'b0;
          i_grant_d = 1'b1;
        end else if (grant_d) begin
          state_d   = SERVE_D;
          // Both d_read and d_write high is resolved as a writeback.
          op_d      = d_write ? OP_WRITE : OP_READ;
          addr_d    = d_address;
          wdata_d   = d_wdata;
          last_d_d  = 1'b1;
          d_grant_d = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      cont_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_grant_q <= i_grant_d;
      d_grant_q <= d_grant_d;
      cont_q    <= cont_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign l2_read          = busy && (op_q == OP_READ);
  assign l2_write         = busy && (op_q == OP_WRITE);
  assign l2_address       = addr_q;
  assign l2_wdata         = wdata_q;
  assign i_resp           = (state_q == SERVE_I) && l2_resp;
  assign d_resp           = (state_q == SERVE_D) && l2_resp;
  assign i_rdata          = i_resp ? l2_rdata : '0;
  assign d_rdata          = d_resp ? l2_rdata : '0;
  assign i_grant_pulse    = i_grant_q;
  assign d_grant_pulse    = d_grant_q;
  assign contention_pulse = cont_q;

  a_no_rw_both : assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("l2_arbiter: d_read and d_write asserted together");

  a_no_resp_idle : assert property (@(posedge clk) disable iff (rst)
                                    !((state_q == IDLE) && l2_resp))
    else $error("l2_arbiter: l2_resp received while idle");

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a round-robin instance and a D-priority instance.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst, rst_dp;
  logic         i_read, d_read, d_write;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata, l2_rdata;
  logic         l2_resp, l2_resp_dp;

  logic [255:0] i_rdata_rr, d_rdata_rr, l2_wdata_rr;
  logic [31:0]  l2_address_rr;
  logic         i_resp_rr, d_resp_rr, l2_read_rr, l2_write_rr, busy_rr;
  logic         i_grant_rr, d_grant_rr, cont_rr;

  logic [255:0] i_rdata_dp, d_rdata_dp, l2_wdata_dp;
  logic [31:0]  l2_address_dp;
  logic         i_resp_dp, d_resp_dp, l2_read_dp, l2_write_dp, busy_dp;
  logic         i_grant_dp, d_grant_dp, cont_dp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(32), .LINE_W(256), .D_PRIORITY(0)) u_rr (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_rr), .i_resp(i_resp_rr),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata_rr), .d_resp(d_resp_rr),
    .l2_read(l2_read_rr), .l2_write(l2_write_rr), .l2_address(l2_address_rr),
    .l2_wdata(l2_wdata_rr), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .busy(busy_rr), .i_grant_pulse(i_grant_rr), .d_grant_pulse(d_grant_rr),
    .contention_pulse(cont_rr)
  );

  l2_arbiter #(.ADDR_W(32), .LINE_W(256), .D_PRIORITY(1)) u_dp (
    .clk(clk), .rst(rst_dp),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_dp), .i_resp(i_resp_dp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata_dp), .d_resp(d_resp_dp),
    .l2_read(l2_read_dp), .l2_write(l2_write_dp), .l2_address(l2_address_dp),
    .l2_wdata(l2_wdata_dp), .l2_rdata(l2_rdata), .l2_resp(l2_resp_dp),
    .busy(busy_dp), .i_grant_pulse(i_grant_dp), .d_grant_pulse(d_grant_dp),
    .contention_pulse(cont_dp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst_dp = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0; l2_resp_dp = 1'b0;

    // Reset state
    step(); step();
    @(negedge clk);
    chk1("rst_busy", busy_rr, 1'b0);
    chk1("rst_l2_read", l2_read_rr, 1'b0);
    chk1("rst_l2_write", l2_write_rr, 1'b0);
    chk1("rst_i_grant", i_grant_rr, 1'b0);
    chk1("rst_contention", cont_rr, 1'b0);
    chka("rst_l2_address", l2_address_rr, 32'h0);
    chkw("rst_l2_wdata", l2_wdata_rr, 256'h0);

    // I read alone
    step(); rst = 1'b0; i_read = 1'b1; i_address = 32'h0000_1000;
    @(negedge clk);
    chk1("t1_pre_grant_busy", busy_rr, 1'b0);
    step(); @(negedge clk);
    chk1("t1_i_grant", i_grant_rr, 1'b1);
    chk1("t1_l2_read", l2_read_rr, 1'b1);
    chk1("t1_busy", busy_rr, 1'b1);
    chka("t1_l2_address", l2_address_rr, 32'h0000_1000);
    step(); @(negedge clk);
    chk1("t1_grant_one_shot", i_grant_rr, 1'b0);
    chk1("t1_no_early_resp", i_resp_rr, 1'b0);
    step(); step(); l2_resp = 1'b1; l2_rdata = {32{8'hAA}};
    @(negedge clk);
    chk1("t1_i_resp", i_resp_rr, 1'b1);
    chkw("t1_i_rdata", i_rdata_rr, {32{8'hAA}});
    chk1("t1_d_resp_quiet", d_resp_rr, 1'b0);
    chkw("t1_d_rdata_zero", d_rdata_rr, 256'h0);
    step(); l2_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    chk1("t1_idle_busy", busy_rr, 1'b0);
    chk1("t1_idle_l2_read", l2_read_rr, 1'b0);
    chk1("t1_idle_i_resp", i_resp_rr, 1'b0);
    chkw("t1_idle_i_rdata_zero", i_rdata_rr, 256'h0);
    step(); @(negedge clk);
    chk1("t1_no_regrant", i_grant_rr, 1'b0);

    // D writeback, address/data changed after grant
    d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = {8{32'h1234_5678}};
    step(); @(negedge clk);
    chk1("t2_d_grant", d_grant_rr, 1'b1);
    chk1("t2_l2_write", l2_write_rr, 1'b1);
    chk1("t2_l2_read_low", l2_read_rr, 1'b0);
    d_address = 32'hDEAD_0000; d_wdata = '0;
    step(); @(negedge clk);
    chka("t2_addr_stable", l2_address_rr, 32'h8000_0040);
    chkw("t2_wdata_latched", l2_wdata_rr, {8{32'h1234_5678}});
    step(); l2_resp = 1'b1; l2_rdata = {32{8'h55}};
    @(negedge clk);
    chk1("t2_d_resp", d_resp_rr, 1'b1);
    chk1("t2_i_resp_quiet", i_resp_rr, 1'b0);
    step(); l2_resp = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk1("t2_idle", busy_rr, 1'b0);
    chk1("t2_d_resp_gone", d_resp_rr, 1'b0);

    // Round-robin contention from reset: I first, then D
    rst = 1'b1;
    step(); rst = 1'b0; i_read = 1'b1; d_read = 1'b1;
    i_address = 32'h0000_2000; d_address = 32'h0000_3000;
    @(negedge clk);
    chk1("t3_reset_busy", busy_rr, 1'b0);
    step(); @(negedge clk);
    chk1("t3_contention", cont_rr, 1'b1);
    chk1("t3_i_first", i_grant_rr, 1'b1);
    chk1("t3_d_not_first", d_grant_rr, 1'b0);
    chka("t3_addr_i", l2_address_rr, 32'h0000_2000);
    step(); @(negedge clk);
    chk1("t3_contention_one_shot", cont_rr, 1'b0);
    step(); l2_resp = 1'b1; l2_rdata = {32{8'h11}};
    @(negedge clk);
    chk1("t3_i_resp", i_resp_rr, 1'b1);
    chk1("t3_d_resp_quiet", d_resp_rr, 1'b0);
    step(); l2_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    chk1("t3_turnaround_idle", busy_rr, 1'b0);
    chk1("t3_turnaround_no_d_grant", d_grant_rr, 1'b0);
    step(); @(negedge clk);
    chk1("t3_d_grant", d_grant_rr, 1'b1);
    chk1("t3_no_contention", cont_rr, 1'b0);
    chka("t3_addr_d", l2_address_rr, 32'h0000_3000);
    chk1("t3_d_l2_read", l2_read_rr, 1'b1);
    step(); l2_resp = 1'b1; l2_rdata = {32{8'h22}};
    @(negedge clk);
    chk1("t3_d_resp", d_resp_rr, 1'b1);
    chkw("t3_d_rdata", d_rdata_rr, {32{8'h22}});
    chkw("t3_i_rdata_zero", i_rdata_rr, 256'h0);
    step(); l2_resp = 1'b0; d_read = 1'b0;
    @(negedge clk);
    chk1("t3_done", busy_rr, 1'b0);

    // Reset while serving D, then a fresh I request
    d_read = 1'b1; d_address = 32'h0000_4000;
    step(); @(negedge clk);
    chk1("t4_serve_d", l2_read_rr, 1'b1);
    step(); rst = 1'b1;
    @(negedge clk);
    chk1("t4_no_resp_before", d_resp_rr, 1'b0);
    step(); rst = 1'b0; d_read = 1'b0; i_read = 1'b1; i_address = 32'h0000_5000;
    @(negedge clk);
    chk1("t4_l2_read_dropped", l2_read_rr, 1'b0);
    chk1("t4_l2_write_dropped", l2_write_rr, 1'b0);
    chk1("t4_busy_cleared", busy_rr, 1'b0);
    chk1("t4_no_d_resp", d_resp_rr, 1'b0);
    step(); @(negedge clk);
    chk1("t4_i_grant", i_grant_rr, 1'b1);
    chka("t4_addr_i", l2_address_rr, 32'h0000_5000);
    step(); l2_resp = 1'b1; l2_rdata = {32{8'h33}};
    @(negedge clk);
    chkw("t4_i_rdata", i_rdata_rr, {32{8'h33}});
    step(); l2_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    chk1("t4_done", busy_rr, 1'b0);

    // I request dropped before l2_resp
    i_read = 1'b1; i_address = 32'h0000_6000;
    step(); @(negedge clk);
    chk1("t5_i_grant", i_grant_rr, 1'b1);
    step(); i_read = 1'b0;
    @(negedge clk);
    chk1("t5_still_reading", l2_read_rr, 1'b1);
    step(); l2_resp = 1'b1; l2_rdata = {32{8'h44}};
    @(negedge clk);
    chk1("t5_i_resp", i_resp_rr, 1'b1);
    chkw("t5_i_rdata", i_rdata_rr, {32{8'h44}});
    step(); l2_resp = 1'b0;
    @(negedge clk);
    chk1("t5_idle", busy_rr, 1'b0);
    chk1("t5_single_resp", i_resp_rr, 1'b0);
    step(); @(negedge clk);
    chk1("t5_no_second_grant", i_grant_rr, 1'b0);
    chk1("t5_still_idle", busy_rr, 1'b0);

    // D priority instance: D wins every contention round
    rst = 1'b1; rst_dp = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_9000; d_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_address = 32'h0000_7000 + 32'(k) * 32'h40;
      step(); @(negedge clk);
      chk1("t6_contention", cont_dp, 1'b1);
      chk1("t6_d_grant", d_grant_dp, 1'b1);
      chk1("t6_i_not_granted", i_grant_dp, 1'b0);
      chka("t6_addr_d", l2_address_dp, 32'h0000_7000 + 32'(k) * 32'h40);
      step(); l2_resp_dp = 1'b1; l2_rdata = {32{8'h66}};
      @(negedge clk);
      chk1("t6_d_resp", d_resp_dp, 1'b1);
      step(); l2_resp_dp = 1'b0;
      @(negedge clk);
      chk1("t6_turnaround", busy_dp, 1'b0);
    end
    d_read = 1'b0;
    step(); @(negedge clk);
    chk1("t6_i_served", i_grant_dp, 1'b1);
    chk1("t6_i_no_contention", cont_dp, 1'b0);
    chka("t6_addr_i", l2_address_dp, 32'h0000_9000);
    step(); l2_resp_dp = 1'b1; l2_rdata = {32{8'h77}};
    @(negedge clk);
    chk1("t6_i_resp", i_resp_dp, 1'b1);
    chkw("t6_i_rdata", i_rdata_dp, {32{8'h77}});
    step(); l2_resp_dp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    chk1("t6_done", busy_dp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L2 cache port between the L1 instruction cache and the L1 data cache.
- Sits between the two L1 miss/writeback interfaces and the L2 request interface.
- Serializes one 256-bit line transaction at a time.
- Exports per-requester activity and contention strobes for the performance counter block.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.
- D_PRIORITY, 0, 0 = round-robin on contention; 1 = data side always wins on contention.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  L1I line read request; held high until i_resp.
- i_address  in  ADDR_W  L1I line address.
- i_rdata  out  LINE_W  line data to L1I.
- i_resp  out  1  one-cycle completion pulse to L1I.
- d_read  in  1  L1D line read request; held until d_resp.
- d_write  in  1  L1D line writeback request; held until d_resp.
- d_address  in  ADDR_W  L1D line address.
- d_wdata  in  LINE_W  L1D writeback data.
- d_rdata  out  LINE_W  line data to L1D.
- d_resp  out  1  one-cycle completion pulse to L1D.
- l2_read  out  1  read request to L2.
- l2_write  out  1  write request to L2.
- l2_address  out  ADDR_W  latched address to L2.
- l2_wdata  out  LINE_W  latched write data to L2.
- l2_rdata  in  LINE_W  L2 line data, valid with l2_resp.
- l2_resp  in  1  L2 completion pulse.
- busy  out  1  a transaction is outstanding.
- i_grant_pulse  out  1  one-cycle strobe when an I transaction is granted.
- d_grant_pulse  out  1  one-cycle strobe when a D transaction is granted.
- contention_pulse  out  1  one-cycle strobe when both sides request in IDLE.

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- Reset values: all outputs 0, last_served = D (so the first round-robin contention goes to I), latched address and data 0.
- IDLE, no request: stay in IDLE, all strobes 0.
- IDLE, only i_read: go to SERVE_I. Latch i_address, latch op = read, pulse i_grant_pulse.
- IDLE, only d_read or d_write: go to SERVE_D. Latch d_address, d_wdata and op, pulse d_grant_pulse.
- IDLE, both sides requesting: pulse contention_pulse.
  - D_PRIORITY=1: grant D.
  - D_PRIORITY=0: grant the side opposite last_served.
- last_served updates on every grant.
- SERVE_x:
  - l2_read or l2_write asserted from latched op; l2_address and l2_wdata driven from the latches, stable for the whole transaction.
  - L2 request appears the cycle after the grant (one cycle of grant latency).
- SERVE_x with l2_resp=1:
  - Same cycle: x_resp = 1 and x_rdata = l2_rdata (combinational pass-through).
  - Next state IDLE; L2 request deasserted from the next cycle.
- Turnaround: there is at least one IDLE cycle between transactions, so a requester that drops its request after its resp is never re-granted spuriously.
- i_rdata and d_rdata are 0 whenever the matching resp is 0.
- d_read and d_write both high: treated as a write (protocol violation; simulation assertion fires).
- Requester drops its request mid-transaction: the L2 transaction still completes and the resp pulse is still issued; no abort path.
- l2_resp while in IDLE: ignored (assertion fires).
- rst mid-transaction: next cycle is IDLE with all L2 requests low. The outstanding L2 request is abandoned; L2 is reset by the same rst.
- busy = state != IDLE.
- Grant and contention strobes are exactly one cycle wide, registered outputs.

Decomposition:
- Shared package l2_arb_types holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D};
  - arb_op_t enum {OP_READ, OP_WRITE};
  - LINE_W and ADDR_W defaults.
- One sub-module, arb_rr_pick: combinational two-way round-robin/priority chooser taking the requests, last_served and D_PRIORITY, returning grant_i / grant_d.
- FSM, latches and strobes live in l2_arbiter.

Test Plan:
- I read alone: i_read=1, i_address=0x0000_1000, L2 responds 3 cycles after l2_read rises with 0xAA..AA → l2_read high from cycle 1; i_resp pulses once with i_rdata=0xAA..AA; i_grant_pulse=1 once; d_resp stays 0.
- D writeback: d_write=1, d_address=0x8000_0040, d_wdata=0x1234..; d_address changed by TB after the grant → l2_write=1, l2_address stays 0x8000_0040, l2_wdata matches the value latched at grant; d_resp pulses once.
- Contention, round-robin (D_PRIORITY=0): I and D request together from reset → I granted first, contention_pulse=1; D granted one cycle after i_resp; l2_address sequence is I address then D address.
- Contention with D_PRIORITY=1: both requesting three times back-to-back → D granted every contention round; I served only after D drops its request.
- Reset mid-transaction: assert rst for 1 cycle while in SERVE_D before l2_resp → next cycle l2_read=l2_write=0, busy=0, no d_resp; a following fresh I request is served normally.
- Request dropped early: i_read falls before l2_resp → i_resp still pulses exactly once; returns to IDLE; no second grant.
